// File: rtl/picomips_pkg.sv
// ---------------------------------------------------------------------------
// Module      : picomips_pkg
// Description : Shared opcode/state types and instruction field constants.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package picomips_pkg;

    localparam int c_OPC_WIDTH = 4;
    localparam int c_OFS_LSB   = 0;

    typedef enum logic [c_OPC_WIDTH-1:0] {
        OP_NOP    = 4'b0000,
        OP_ADD    = 4'b0001,
        OP_ALU2   = 4'b0010,
        OP_ALU3   = 4'b0011,
        OP_ALU4   = 4'b0100,
        OP_ALU5   = 4'b0101,
        OP_ALU6   = 4'b0110,
        OP_ALU7   = 4'b0111,
        OP_JMP    = 4'b1000,
        OP_BEQ    = 4'b1001,
        OP_BNE    = 4'b1010,
        OP_WAITIN = 4'b1011,
        OP_RSV0   = 4'b1100,
        OP_RSV1   = 4'b1101,
        OP_RSV2   = 4'b1110,
        OP_HALT   = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_seq_decode.sv
// ---------------------------------------------------------------------------
// Module      : pc_seq_decode
// Description : Combinational opcode class decoder for the PC sequencer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_seq_decode
    import picomips_pkg::*;
(
    input  opcode_t opcode,
    output logic    is_alu,
    output logic    is_jmp,
    output logic    is_beq,
    output logic    is_bne,
    output logic    is_waitin,
    output logic    is_halt
);

    always_comb begin
        is_alu    = 1'b0;
        is_jmp    = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_waitin = 1'b0;
        is_halt   = 1'b0;
        // NOP and the reserved codes decode to no class and fall through to PC+1
        case (opcode)
            OP_ADD, OP_ALU2, OP_ALU3, OP_ALU4,
            OP_ALU5, OP_ALU6, OP_ALU7:   is_alu    = 1'b1;
            OP_JMP:                      is_jmp    = 1'b1;
            OP_BEQ:                      is_beq    = 1'b1;
            OP_BNE:                      is_bne    = 1'b1;
            OP_WAITIN:                   is_waitin = 1'b1;
            OP_HALT:                     is_halt   = 1'b1;
            default:                     ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// Module      : pc_sequencer
// Description : Mealy program-counter sequencer with branch, input wait, halt.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int Psize = 4,
    parameter int Isize = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] instr,
    input  logic             alu_zero,
    input  logic             in_valid,
    output logic             in_ack,
    output logic             PCincr,
    output logic             PCrelbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic             halted
);

    state_t  r_state;
    state_t  w_state_next;
    logic    r_zflag;
    logic    r_armed;
    opcode_t w_opcode;
    logic    w_is_alu;
    logic    w_is_jmp;
    logic    w_is_beq;
    logic    w_is_bne;
    logic    w_is_waitin;
    logic    w_is_halt;
    logic    w_accept;

    assign w_opcode = opcode_t'(instr[Isize-1 -: c_OPC_WIDTH]);

    generate
        if (Isize - c_OPC_WIDTH > Psize) begin : g_unused_mid
            logic w_unused_mid;
            assign w_unused_mid = ^instr[Isize-c_OPC_WIDTH-1:Psize];
        end
    endgenerate

    pc_seq_decode u_decode (
        .opcode    (w_opcode),
        .is_alu    (w_is_alu),
        .is_jmp    (w_is_jmp),
        .is_beq    (w_is_beq),
        .is_bne    (w_is_bne),
        .is_waitin (w_is_waitin),
        .is_halt   (w_is_halt)
    );

    // Handshake completes only on a fresh rising edge of in_valid (armed by a low cycle)
    assign w_accept = r_armed & in_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_zflag <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_is_alu) begin
                r_zflag <= alu_zero;
            end
            if (in_ack) begin
                r_armed <= 1'b0;
            end else if (!in_valid) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_is_halt) begin
                    w_state_next = ST_HALT;
                end else if (w_is_waitin && !w_accept) begin
                    w_state_next = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT:    w_state_next = ST_HALT;
            default:    w_state_next = ST_RUN;
        endcase
    end

    // All outputs are gated by reset so nothing leaks during a reset cycle
    always_comb begin
        in_ack      = 1'b0;
        PCincr      = 1'b0;
        PCrelbranch = 1'b0;
        halted      = 1'b0;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_is_halt) begin
                        PCincr = 1'b0;
                    end else if (w_is_waitin) begin
                        in_ack = w_accept;
                        PCincr = w_accept;
                    end else if (w_is_jmp) begin
                        PCrelbranch = 1'b1;
                    end else if (w_is_beq) begin
                        PCrelbranch = r_zflag;
                        PCincr      = ~r_zflag;
                    end else if (w_is_bne) begin
                        PCrelbranch = ~r_zflag;
                        PCincr      = r_zflag;
                    end else begin
                        PCincr = 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    in_ack = w_accept;
                    PCincr = w_accept;
                end
                ST_HALT:    halted = 1'b1;
                default:    ;
            endcase
        end
    end

    assign Branchaddr = PCrelbranch ? instr[Psize-1:c_OFS_LSB] : '0;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter Psize, default 4: program counter and branch offset width.
REQ-002 Parameter Isize, default 12: instruction word width; opcode is instr[Isize-1:Isize-4], offset is instr[Psize-1:0].
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 instr  input  Isize  instruction currently addressed by the program counter.
REQ-006 alu_zero  input  1  ALU result-is-zero for the current instruction.
REQ-007 in_valid  input  1  external input data ready, for the WAITIN handshake.
REQ-008 in_ack  output  1  one-cycle pulse: the external input was consumed.
REQ-009 PCincr  output  1  program counter increments by 1.
REQ-010 PCrelbranch  output  1  program counter adds Branchaddr.
REQ-011 Branchaddr  output  Psize  two's-complement relative offset.
REQ-012 halted  output  1  sequencer stopped by HALT.

Function
REQ-013 The opcode map SHALL be as follows:
- 4'b0000: NOP.
- 4'b0001 to 4'b0111: ALU class.
- 4'b1000: JMP.
- 4'b1001: BEQ.
- 4'b1010: BNE.
- 4'b1011: WAITIN.
- 4'b1111: HALT.
- 4'b1100 to 4'b1110: reserved, executed as NOP.
REQ-014 The FSM SHALL have exactly three states: RUN, WAIT_IN and HALT. It SHALL enter RUN on reset.
REQ-015 Outputs SHALL be combinational from state, instr, zflag, armed and in_valid (Mealy), so the PC acts in the same cycle.
REQ-016 PCincr and PCrelbranch SHALL never both be 1 in any cycle.
REQ-017 Branchaddr SHALL equal instr[Psize-1:0] when PCrelbranch=1, and 0 otherwise.
REQ-018 In RUN, NOP, ALU and reserved opcodes SHALL assert PCincr.
REQ-019 In RUN, JMP SHALL assert PCrelbranch.
REQ-020 In RUN, BEQ SHALL assert PCrelbranch if zflag=1, else PCincr. BNE SHALL do the inverse.
REQ-021 zflag SHALL load alu_zero on every RUN cycle executing an ALU-class opcode. It SHALL hold its value otherwise.
REQ-022 armed SHALL set on any cycle with in_valid=0 and clear on any cycle with in_ack=1.
REQ-023 In RUN, WAITIN with armed=1 and in_valid=1 SHALL assert in_ack and PCincr, and stay in RUN. Otherwise it SHALL assert nothing and go to WAIT_IN.
REQ-024 In WAIT_IN, PCincr, PCrelbranch and in_ack SHALL stay 0 until armed=1 and in_valid=1. In that cycle the block SHALL assert in_ack and PCincr and go to RUN.
REQ-025 In RUN, HALT SHALL assert nothing and go to HALT.
REQ-026 In HALT, halted SHALL be 1 and all other outputs 0, regardless of instr or in_valid, until reset.
REQ-027 A JMP with offset 0 SHALL assert PCrelbranch with Branchaddr=0, giving a legal PC self-loop. Wrap-around is the PC's modulo-2^Psize arithmetic.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL set state=RUN, zflag=0 and armed=0.
REQ-029 During a cycle with reset=0, all outputs SHALL be 0.
REQ-030 Reset SHALL take effect from any state, including WAIT_IN and HALT. A half-complete handshake SHALL be abandoned and no in_ack issued.

Structure
REQ-031 A shared package picomips_pkg SHALL hold:
- the opcode enum;
- the state enum;
- the opcode field position constants.
REQ-032 Decoding SHALL be one combinational sub-module, pc_seq_decode, with outputs is_alu, is_jmp, is_beq, is_bne, is_waitin and is_halt. The FSM and registers SHALL stay in pc_sequencer.

Verification
REQ-033 Reset: hold reset=0 for 2 cycles with instr=ADD (0001) -> all outputs 0. First cycle after release -> PCincr=1.
REQ-034 Branch: zflag=1 (ALU op with alu_zero=1), then BEQ with offset 4'hD -> PCrelbranch=1, Branchaddr=4'hD, PCincr=0. Same with zflag=0 -> PCincr=1, Branchaddr=0.
REQ-035 Handshake: WAITIN, in_valid=0 for 3 cycles, then 1 -> 3 cycles with no PC action, then one cycle of in_ack=1 and PCincr=1. in_valid held at 1 into a second WAITIN -> no in_ack until in_valid drops and rises again.
REQ-036 Halt: HALT, then instr changed every cycle for 10 cycles -> halted=1, PCincr=PCrelbranch=in_ack=0 throughout. reset=0 for one cycle -> halted=0.
REQ-037 Reset mid-wait: in WAIT_IN, reset=0 for one cycle while in_valid=1 -> no in_ack. Afterwards state=RUN and armed=0.
REQ-038 Random instr, alu_zero and in_valid stream over 10k cycles -> assertion that PCincr and PCrelbranch are never both 1 and in_ack is never 1 for two consecutive cycles.
